// File: rtl/disp_scan_if.sv
// disp_scan_if: display word in, digit select / nibble / frame pulse out.
// master drives the display word, slave is the scan controller.
interface disp_scan_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  sel;
  logic [3:0]  hex;
  logic        frame_tick;

  modport master (
    output en, digits, blink_mask,
    input  sel, hex, frame_tick
  );

  modport slave (
    input  en, digits, blink_mask,
    output sel, hex, frame_tick
  );
endinterface

// File: rtl/disp_scan.sv
// disp_scan: 4-digit seven-segment scan controller with blanking guard.
// Optional per-digit blink is built when DISP_BLINK_EN is defined.
module disp_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  disp_scan_if.slave  bus
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SD_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BC_LAST =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic          start;
  logic          wrap;
  logic          blank;
  logic [15:0]   snap;
  logic [3:0]    one;

  assign one  = 4'b0001;
  assign wrap = start && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // start marks the edge that enters DRIVE for digit 0
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    start   = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = DRIVE;
          cnt_n   = '0;
          idx_n   = '0;
          start   = 1'b1;
        end
        DRIVE: begin
          if (cnt == SD_LAST) begin
            cnt_n = '0;
            if (BLANK_CYC == 0) begin
              idx_n = idx + 2'd1;
              start = (idx == 2'd3);
            end else begin
              state_n = GUARD;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        GUARD: begin
          if (cnt == BC_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
            start   = (idx == 2'd3);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] BF_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt;
  logic          phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (state_n == IDLE) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (fcnt == BF_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign blank = phase & bus.blink_mask[idx];
`else
  logic unused_ok;
  assign unused_ok = ^{bus.blink_mask, BLINK_FRAMES[0], wrap};
  assign blank     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap           <= '0;
      bus.sel        <= 4'hF;
      bus.hex        <= 4'h0;
      bus.frame_tick <= 1'b0;
    end else begin
      if (start) snap <= bus.digits;
      bus.sel <= 4'hF;
      if (state == DRIVE && !blank) bus.sel <= ~(one << idx);
      if (state == DRIVE) bus.hex <= snap[{idx, 2'b00} +: 4];
      bus.frame_tick <= (state == DRIVE) && (idx == 2'd0)
                        && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: directed checks of disp_scan with and without guard slot.
// Blink expectations apply when DISP_BLINK_EN is defined.
module tb_disp_scan;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_scan_if b0();
  disp_scan_if b1();

  disp_scan #(
    .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  disp_scan #(
    .SCAN_DIV(4), .BLANK_CYC(0), .BLINK_FRAMES(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] W_A = 16'h4321;
  localparam logic [15:0] W_B = 16'hABCD;
  localparam logic [3:0]  MASK = 4'b0100;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic e, input logic [15:0] d);
    b0.en = e;  b0.digits = d;  b0.blink_mask = MASK;
    b1.en = e;  b1.digits = d;  b1.blink_mask = MASK;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // {sel, hex, frame_tick} seen after the k-th edge since enable
  function automatic logic [8:0] model(input int k, input int bc,
                                       input logic [15:0] w);
    int sl, per, p, f, slot, off;
    logic [3:0] s, one, m;
    sl   = 4 + bc;
    per  = 4 * sl;
    p    = (k - 1) % per;
    f    = (k - 1) / per;
    slot = p / sl;
    off  = p % sl;
    one  = 4'b0001;
    m    = MASK;
    s    = (off < 4) ? ~(one << slot) : 4'hF;
`ifdef DISP_BLINK_EN
    if (off < 4 && m[slot] && ((f / 2) % 2 == 1)) s = 4'hF;
`else
    if (m[slot] && f < 0) s = 4'hF;
`endif
    return {s, w[slot*4 +: 4], (p == 0)};
  endfunction

  task automatic cmp(input string ph, input int k,
                     input logic [15:0] w0, input logic [15:0] w1);
    chk($sformatf("%s u0 k=%0d", ph, k),
        {23'd0, b0.sel, b0.hex, b0.frame_tick}, {23'd0, model(k, 1, w0)});
    chk($sformatf("%s u1 k=%0d", ph, k),
        {23'd0, b1.sel, b1.hex, b1.frame_tick}, {23'd0, model(k, 0, w1)});
    chk($sformatf("%s onehot u0 k=%0d", ph, k),
        32'($countones(~b0.sel) <= 1), 32'd1);
    chk($sformatf("%s onehot u1 k=%0d", ph, k),
        32'($countones(~b1.sel) <= 1), 32'd1);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " u0"}, {27'd0, b0.sel, b0.frame_tick}, {27'd0, 4'hF, 1'b0});
    chk({tag, " u1"}, {27'd0, b1.sel, b1.frame_tick}, {27'd0, 4'hF, 1'b0});
  endtask

  initial begin
    drv(1'b0, W_A);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst u0", {23'd0, b0.sel, b0.hex, b0.frame_tick}, {23'd0, 9'h1E0});
    chk("rst u1", {23'd0, b1.sel, b1.hex, b1.frame_tick}, {23'd0, 9'h1E0});
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle u0 c=%0d", i),
          {23'd0, b0.sel, b0.hex, b0.frame_tick}, {23'd0, 9'h1E0});
      chk($sformatf("idle u1 c=%0d", i),
          {23'd0, b1.sel, b1.hex, b1.frame_tick}, {23'd0, 9'h1E0});
    end

    // steady scan; new word lands mid-frame 1 and shows from frame 2
    drv(1'b1, W_A);
    @(posedge clk);
    @(negedge clk);
    chk_dark("enable lag");
    for (int k = 1; k <= 84; k++) begin
      step();
      cmp("scan", k,
          (((k - 1) / 20) >= 2) ? W_B : W_A,
          (((k - 1) / 16) >= 2) ? W_B : W_A);
      if (k == 27) drv(1'b1, W_B);
    end

    drv(1'b0, W_B);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dark($sformatf("off c=%0d", i));
    end

    // drop enable inside digit 2 drive slot, re-enable 3 edges later
    drv(1'b1, W_B);
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      step();
      cmp("pre", k, W_B, W_B);
    end
    drv(1'b0, W_B);
    step();
    cmp("pre", 13, W_B, W_B);
    for (int k = 14; k <= 16; k++) begin
      step();
      chk_dark($sformatf("drop k=%0d", k));
      if (k == 15) drv(1'b1, W_B);
    end
    for (int k = 17; k <= 40; k++) begin
      step();
      cmp("restart", k - 16, W_B, W_B);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
# disp_scan

Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. It snapshots a 16-bit, four-nibble display word once per frame and steps through the digits, presenting one nibble and one active-low digit select per slot. Between slots it inserts a blanking guard so that segments do not ghost onto the next digit. Its `hex`/`sel` outputs feed the existing hex-to-segment decoder directly; the decoder passes `sel` through to the anodes.

## Interface
- `SCAN_DIV`, 50000: clock cycles each digit is driven (DRIVE slot length); must be ≥1.
- `BLANK_CYC`, 500: clock cycles of all-digits-off guard after each DRIVE slot; 0 means no guard.
- `BLINK_FRAMES`, 125: frames per blink half-period (used only with `DISP_BLINK_EN`); must be ≥1.
- `clk` input, 1: system clock. All logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `en` input, 1: scan enable. When 0, the display is dark.
- `digits` input, 16: display word. Nibble `[4i+3:4i]` is digit i; digit 0 is rightmost.
- `blink_mask` input, 4: per-digit blink enable, bit i for digit i.
- `sel` output, 4: active-low one-hot digit select. `1110` selects digit 0, `0111` selects digit 3, `1111` selects none.
- `hex` output, 4: nibble for the currently selected digit.
- `frame_tick` output, 1: one-cycle pulse on the first DRIVE cycle of digit 0.

## Operation
- States: IDLE, DRIVE, GUARD. A cycle counter `cnt` and a 2-bit digit index `idx` are kept.
- IDLE: `sel=1111`; `idx` and `cnt` are held at 0. `en=1` moves to DRIVE on the next edge.
- Entry to DRIVE with `idx=0`:
  - `digits` is captured into a snapshot register. The whole frame uses this snapshot, so there is no tearing mid-frame.
  - `frame_tick` is asserted.
- DRIVE:
  - `hex` = snapshot nibble `idx`.
  - `sel` = `~(4'b0001 << idx)`.
  - Lasts exactly `SCAN_DIV` cycles.
  - Then goes to GUARD, or, if `BLANK_CYC=0`, straight to DRIVE with `idx+1`.
- GUARD:
  - `sel=1111`; `hex` holds its last value.
  - Lasts exactly `BLANK_CYC` cycles, then goes to DRIVE with `idx+1`.
- `idx` wraps 3→0. The wrap starts a new frame: new snapshot and `frame_tick` pulse.
- `en` falling in any state: next edge goes to IDLE, `sel=1111`, `idx=0`, `cnt=0`, and any partial frame is discarded. Re-enabling always starts at digit 0.
- `en` rising on the same edge that a slot ends: IDLE entry still takes priority only when `en=0`. With `en=1`, the normal sequence continues.
- All outputs are registered. Decode from state is not exposed combinationally.

## Timing
- Reset values: `sel=1111`, `hex=0000`, `frame_tick=0`, state IDLE, `idx=0`, `cnt=0`, snapshot `0`, blink phase 0.
- `en` sampled 1 at edge N: `sel=1110` and `frame_tick=1` are visible after edge N+1.
- Frame period = 4·(`SCAN_DIV`+`BLANK_CYC`) cycles.
- `frame_tick` spacing is exactly one frame period while `en` stays 1.
- `digits` changes are visible at the next frame start only. Capture happens on the edge that enters DRIVE with `idx=0`.
- Counter width is `$clog2(max(SCAN_DIV,BLANK_CYC))`, minimum 1 bit. It counts 0..limit-1 and then clears.
- `sel` never has more than one bit low in any cycle.

## Configuration
- `DISP_BLINK_EN` defined:
  - A frame counter (0..`BLINK_FRAMES`-1) toggles blink phase on wrap; it advances on `frame_tick`.
  - While phase=1, each DRIVE slot whose `blink_mask[idx]=1` outputs `sel=1111`. `hex` is still updated, and slot timing is unchanged.
  - The frame counter and phase clear in IDLE.
- `DISP_BLINK_EN` undefined:
  - `blink_mask` is ignored and no blink logic is synthesized.
  - `sel` follows the DRIVE/GUARD rules only.

## Test plan
Parameters for all scenarios: `SCAN_DIV=4`, `BLANK_CYC=1`, `BLINK_FRAMES=2`.
- Reset, then `en=0` for 20 cycles -> `sel=1111`, `hex=0`, `frame_tick=0` throughout.
- `digits=16'h4321`, `en=1` -> `sel` sequence is 1110×4, 1111×1, 1101×4, 1111, 1011×4, 1111, 0111×4, 1111, repeating. `hex` is 1,2,3,4 in the matching slots. `frame_tick` occurs every 20 cycles.
- Change `digits` to `16'hABCD` during digit 1's slot -> the remaining slots of that frame show 3,4. The next frame shows D,C,B,A.
- Drop `en` during digit 2's DRIVE, then raise it 3 cycles later -> `sel=1111` on the next cycle. Restart is at `sel=1110` with `frame_tick=1`.
- `BLANK_CYC=0` variant -> no 1111 cycles between digits. Frame period is 16 cycles.
- `DISP_BLINK_EN` defined, `blink_mask=4'b0100` -> digit 2's slot shows `sel=1111` during frames 2–3, 6–7, and so on. All other digits are unaffected.
